// File: rtl/vstride_addrgen.sv
// rtl/vstride_addrgen.sv - strided vector address generator
//
// Purpose:
//   On a start command, reads one stride from the stride register file, then
//   emits vl element addresses (base, base+s, base+2s, ...) over a
//   valid/ready interface at up to one address per cycle.
//   Sits between vector instruction decode and the vector load/store unit.
//
// Optional feature (macro VSTRIDE_ELEMSCALE_EN):
//   Adds input esize[1:0] (0=byte .. 3=dword), sampled with start. The
//   effective stride becomes sr_data << esize, truncated to WIDTH. The base
//   is not scaled. When the macro is undefined, sr_data is a byte stride.
//
// Ports:
//   clk, resetn       clock, asynchronous active-low reset
//   start             command pulse, sampled only while idle
//   flush             synchronous abort, back to idle next cycle, no done
//   base              base address (sampled with start)
//   stride_reg        stride register index (sampled with start)
//   vl                vector length 0..MVL (sampled with start)
//   esize             element size shift (only with VSTRIDE_ELEMSCALE_EN)
//   sr_reg, sr_en     stride register file read address / enable
//   sr_data           stride register file data, valid the cycle after sr_en
//   addr, addr_idx    element address and its index
//   addr_last         marks the final element
//   addr_valid/ready  element handshake
//   busy              high whenever not idle
//   done              one-cycle pulse after the last element is accepted

module vstride_addrgen #(
  parameter int WIDTH       = 32,
  parameter int LOG2NUMREGS = 3,
  parameter int LOG2MVL     = 6
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       base,
  input  logic [LOG2NUMREGS-1:0] stride_reg,
  input  logic [LOG2MVL:0]       vl,
`ifdef VSTRIDE_ELEMSCALE_EN
  input  logic [1:0]             esize,
`endif
  output logic [LOG2NUMREGS-1:0] sr_reg,
  output logic                   sr_en,
  input  logic [WIDTH-1:0]       sr_data,
  output logic [WIDTH-1:0]       addr,
  output logic [LOG2MVL-1:0]     addr_idx,
  output logic                   addr_last,
  output logic                   addr_valid,
  input  logic                   addr_ready,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_GEN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [LOG2MVL:0] C_MVL = {1'b1, {LOG2MVL{1'b0}}};
  localparam logic [LOG2MVL:0] C_ONE = (LOG2MVL+1)'(1);
  localparam logic [LOG2MVL:0] C_TWO = (LOG2MVL+1)'(2);

  state_t                 r_state;
  logic [WIDTH-1:0]       r_base;
  logic [WIDTH-1:0]       r_stride;
  logic [WIDTH-1:0]       r_addr;
  logic [LOG2MVL:0]       r_vl;
  logic [LOG2MVL:0]       r_remain;
  logic [LOG2MVL-1:0]     r_idx;
  logic [LOG2NUMREGS-1:0] r_sr_reg;
  logic                   r_sr_en;
  logic                   r_valid;
  logic                   r_last;
  logic                   r_busy;
  logic                   r_done;

  logic [WIDTH-1:0]       w_stride_eff;
  logic [LOG2MVL:0]       w_vl_clamped;
  logic                   w_accept;

`ifdef VSTRIDE_ELEMSCALE_EN
  logic [1:0]             r_esize;
  // Shift by element size; bits shifted past WIDTH are dropped.
  assign w_stride_eff = sr_data << r_esize;
`else
  assign w_stride_eff = sr_data;
`endif

  // Lengths above MVL would overrun the element index; saturate them.
  assign w_vl_clamped = (vl > C_MVL) ? C_MVL : vl;
  assign w_accept     = r_valid & addr_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_base   <= '0;
      r_stride <= '0;
      r_addr   <= '0;
      r_vl     <= '0;
      r_remain <= '0;
      r_idx    <= '0;
      r_sr_reg <= '0;
      r_sr_en  <= 1'b0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef VSTRIDE_ELEMSCALE_EN
      r_esize  <= '0;
`endif
    end else if (flush) begin
      // Abort wins over every transition; a pending read is simply dropped
      // because LOAD is never reached.
      r_state <= S_IDLE;
      r_sr_en <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_busy <= 1'b1;
            if (vl == '0) begin
              // Empty vector: skip the register read and report done.
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state  <= S_FETCH;
              r_base   <= base;
              r_vl     <= w_vl_clamped;
              r_sr_reg <= stride_reg;
              r_sr_en  <= 1'b1;
`ifdef VSTRIDE_ELEMSCALE_EN
              r_esize  <= esize;
`endif
            end
          end
        end

        S_FETCH: begin
          // sr_en was high for exactly this cycle; data arrives during LOAD.
          r_sr_en <= 1'b0;
          r_state <= S_LOAD;
        end

        S_LOAD: begin
          r_stride <= w_stride_eff;
          r_addr   <= r_base;
          r_idx    <= '0;
          r_remain <= r_vl;
          r_valid  <= 1'b1;
          r_last   <= (r_vl == C_ONE);
          r_state  <= S_GEN;
        end

        S_GEN: begin
          if (w_accept) begin
            if (r_remain == C_ONE) begin
              // Final element taken; index is not advanced so it never
              // wraps at vl = MVL.
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_addr   <= r_addr + r_stride;
              r_idx    <= r_idx + LOG2MVL'(1);
              r_remain <= r_remain - C_ONE;
              r_last   <= (r_remain == C_TWO);
            end
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_sr_en <= 1'b0;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign sr_reg     = r_sr_reg;
  assign sr_en      = r_sr_en;
  assign addr       = r_addr;
  assign addr_idx   = r_idx;
  assign addr_last  = r_last;
  assign addr_valid = r_valid;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_vstride_addrgen.sv
// tb/tb_vstride_addrgen.sv - self-checking bench for vstride_addrgen
module tb_vstride_addrgen;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        flush;
  logic [31:0] base;
  logic [2:0]  stride_reg;
  logic [6:0]  vl;
  logic [1:0]  esize;
  logic [2:0]  sr_reg;
  logic        sr_en;
  logic [31:0] sr_data;
  logic [31:0] addr;
  logic [5:0]  addr_idx;
  logic        addr_last;
  logic        addr_valid;
  logic        addr_ready;
  logic        busy;
  logic        done;

  int total;
  int bad;

  logic [31:0] regs [8];

  vstride_addrgen #(.WIDTH(32), .LOG2NUMREGS(3), .LOG2MVL(6)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .flush      (flush),
    .base       (base),
    .stride_reg (stride_reg),
    .vl         (vl),
`ifdef VSTRIDE_ELEMSCALE_EN
    .esize      (esize),
`endif
    .sr_reg     (sr_reg),
    .sr_en      (sr_en),
    .sr_data    (sr_data),
    .addr       (addr),
    .addr_idx   (addr_idx),
    .addr_last  (addr_last),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stride register file: registered read, data valid the cycle after sr_en.
  always @(posedge clk) begin
    if (sr_en) sr_data <= regs[sr_reg];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One command, checked against base + k*stride for k = 0..n-1.
  // mode: 0 ready always, 1 random ready, 2 stall element 1 for two cycles.
  task automatic run_cmd(input logic [31:0] b, input logic [2:0] sreg, input logic [6:0] n,
                         input int mode, input int restart_at, input int flush_at_idx);
    logic [31:0] strd;
    logic [31:0] kk;
    logic [31:0] exp_a;
    logic [31:0] h_addr;
    logic [5:0]  h_idx;
    logic        h_last;
    logic        pend_stall;
    logic        rdy;
    int hs, sr_en_cnt, done_cnt, first_valid, done_cyc, last_hs_cyc, stalls, flush_cyc;
    bit finished;
    strd = regs[sreg] << esize;
    hs = 0; sr_en_cnt = 0; done_cnt = 0; first_valid = -1; done_cyc = -1;
    last_hs_cyc = -1; stalls = 0; flush_cyc = -1; finished = 0; pend_stall = 0;
    h_addr = '0; h_idx = '0; h_last = 1'b0;
    @(negedge clk);
    start = 1'b1; base = b; stride_reg = sreg; vl = n; addr_ready = 1'b1; flush = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      start = (cyc == restart_at);
      if (cyc == restart_at) begin
        base = ~b; stride_reg = 3'(sreg + 3'd1); vl = 7'd2;
      end
      flush = 1'b0;
      if (sr_en) begin
        sr_en_cnt++;
        chk("sr_reg", 64'(sr_reg), 64'(sreg));
      end
      if (addr_valid && first_valid < 0) first_valid = cyc;
      if (pend_stall) begin
        chk("stall_addr", 64'(addr), 64'(h_addr));
        chk("stall_idx", 64'(addr_idx), 64'(h_idx));
        chk("stall_last", 64'(addr_last), 64'(h_last));
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (flush_cyc >= 0 && cyc == flush_cyc + 1) begin
        chk("flush_valid", 64'(addr_valid), 64'(0));
        chk("flush_busy", 64'(busy), 64'(0));
        chk("flush_done", 64'(done), 64'(0));
      end
      if (flush_cyc >= 0 && cyc == flush_cyc + 4) begin
        finished = 1; break;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        chk("post_busy", 64'(busy), 64'(0));
        chk("post_done", 64'(done), 64'(0));
        finished = 1; break;
      end
      case (mode)
        1: rdy = ($urandom_range(0, 3) != 0);
        2: begin
          rdy = 1'b1;
          if (addr_valid && addr_idx == 6'd1 && stalls < 2) begin
            rdy = 1'b0; stalls++;
          end
        end
        default: rdy = 1'b1;
      endcase
      addr_ready = rdy;
      if (flush_at_idx >= 0 && flush_cyc < 0 && addr_valid && int'(addr_idx) == flush_at_idx) begin
        flush = 1'b1; flush_cyc = cyc;
      end
      if (addr_valid && rdy && !flush) begin
        kk = hs;
        exp_a = b + kk * strd;
        chk("addr", 64'(addr), 64'(exp_a));
        chk("idx", 64'(addr_idx), 64'(hs));
        chk("last", 64'(addr_last), 64'(hs == int'(n) - 1));
        hs++; last_hs_cyc = cyc;
      end
      pend_stall = addr_valid && !rdy && !flush;
      h_addr = addr; h_idx = addr_idx; h_last = addr_last;
    end
    start = 1'b0; flush = 1'b0; addr_ready = 1'b1;
    chk("complete", 64'(finished), 64'(1));
    if (flush_at_idx < 0) begin
      chk("hs_count", 64'(hs), 64'(n));
      chk("done_count", 64'(done_cnt), 64'(1));
      chk("sr_en_count", 64'(sr_en_cnt), 64'(n != 0));
      chk("first_valid", 64'(first_valid), 64'((n != 0) ? 3 : -1));
      chk("done_cycle", 64'(done_cyc), 64'((n != 0) ? last_hs_cyc + 1 : 1));
    end else begin
      chk("flush_hs", 64'(hs), 64'(flush_at_idx));
      chk("flush_no_done", 64'(done_cnt), 64'(0));
    end
  endtask

  initial begin
    total = 0; bad = 0;
    resetn = 1'b0; start = 1'b0; flush = 1'b0; base = '0; stride_reg = '0;
    vl = '0; esize = 2'd0; addr_ready = 1'b1; sr_data = '0;
    for (int i = 0; i < 8; i++) regs[i] = 32'(i) * 32'h100;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_addr_valid", 64'(addr_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_sr_en", 64'(sr_en), 64'(0));
    chk("rst_addr", 64'(addr), 64'(0));
    chk("rst_idx", 64'(addr_idx), 64'(0));
    chk("rst_last", 64'(addr_last), 64'(0));
    chk("rst_sr_reg", 64'(sr_reg), 64'(0));
    resetn = 1'b1;

    // Basic positive stride
    regs[2] = 32'd4;
    run_cmd(32'h1000, 3'd2, 7'd4, 0, 0, -1);
    // Negative stride wrapping through zero
    regs[5] = 32'hFFFF_FFF8;
    run_cmd(32'h8, 3'd5, 7'd3, 0, 0, -1);
    // Backpressure on element 1
    regs[1] = 32'd16;
    run_cmd(32'h2000, 3'd1, 7'd3, 2, 0, -1);
    // Empty vector
    run_cmd(32'h3000, 3'd4, 7'd0, 0, 0, -1);
    // Start while busy is ignored
    regs[6] = 32'd12;
    run_cmd(32'h4000, 3'd6, 7'd8, 0, 5, -1);
    // Full MVL length and single element
    regs[7] = 32'h40;
    run_cmd(32'hFFFF_F000, 3'd7, 7'd64, 0, 0, -1);
    run_cmd(32'h5000, 3'd3, 7'd1, 0, 0, -1);

    // Random commands with random backpressure
    for (int t = 0; t < 16; t++) begin
      logic [2:0] rs;
      logic [6:0] rn;
      rs = 3'($urandom_range(0, 7));
      regs[rs] = $urandom;
      rn = (t == 0) ? 7'd64 : 7'($urandom_range(1, 64));
      run_cmd($urandom, rs, rn, 1, 0, -1);
    end

    // Flush at element 5 of a full-length vector
    run_cmd(32'h6000, 3'd2, 7'd64, 0, 0, 5);

    // Asynchronous reset in the middle of generation
    @(negedge clk);
    start = 1'b1; base = 32'h7000; stride_reg = 3'd2; vl = 7'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_valid", 64'(addr_valid), 64'(1));
    #1 resetn = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(addr_valid), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_addr", 64'(addr), 64'(0));
    chk("mid_rst_idx", 64'(addr_idx), 64'(0));
    chk("mid_rst_sr_reg", 64'(sr_reg), 64'(0));
    chk("mid_rst_done", 64'(done), 64'(0));
    @(negedge clk);
    resetn = 1'b1;
    run_cmd(32'h1000, 3'd2, 7'd4, 0, 0, -1);

`ifdef VSTRIDE_ELEMSCALE_EN
    esize = 2'd2;
    regs[3] = 32'd3;
    run_cmd(32'h0, 3'd3, 7'd3, 0, 0, -1);
    esize = 2'd0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
